// File: rtl/btn_evt_pkg.sv
// Shared types and default timing for the button gesture decoder.
// The default periods assume the 100 kHz tick clock.
package btn_evt_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    HELD   = 3'd4
  } state_t;

  localparam int LONG_PRDS_DEF   = 100000;
  localparam int DCLICK_PRDS_DEF = 30000;
  localparam int REPEAT_PRDS_DEF = 20000;
  localparam int CNTW_DEF        = 17;

endpackage

// File: rtl/btn_edge_detect.sv
// Converts the debounced button level into active-high form and flags press/release edges.
// The previous-level register resets to "not pressed", so a button held through reset yields a press edge.
module btn_edge_detect #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_act_prev,
  output logic o_press_edge,
  output logic o_rel_edge
);

  logic w_act;
  logic r_act_prev;

  assign w_act = i_btn ^ ACTIVE_LOW;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_act_prev <= 1'b0;
    end else begin
      r_act_prev <= w_act;
    end
  end

  assign o_act_prev   = r_act_prev;
  assign o_press_edge = w_act & ~r_act_prev;
  assign o_rel_edge   = ~w_act & r_act_prev;

endmodule

// File: rtl/button_event_decoder.sv
// Classifies debounced button gestures into single-cycle short / double / long / repeat pulses.
// One shared timer measures every state's dwell; edges always take priority over timeouts.
module button_event_decoder
  import btn_evt_pkg::*;
#(
  parameter bit ACTIVE_LOW  = 1'b1,
  parameter int LONG_PRDS   = LONG_PRDS_DEF,
  parameter int DCLICK_PRDS = DCLICK_PRDS_DEF,
  parameter int REPEAT_PRDS = REPEAT_PRDS_DEF,
  parameter int CNTW        = CNTW_DEF
) (
  input  logic clk_100K,
  input  logic rst_n,
  input  logic btn_i,
  output logic pressed,
  output logic evt_short,
  output logic evt_double,
  output logic evt_long,
  output logic evt_repeat
);

  localparam logic [CNTW-1:0] LONG_LAST   = CNTW'(LONG_PRDS - 1);
  localparam logic [CNTW-1:0] DCLICK_LAST = CNTW'(DCLICK_PRDS - 1);
  localparam logic [CNTW-1:0] REPEAT_LAST = CNTW'(REPEAT_PRDS - 1);
  localparam logic [CNTW-1:0] TIMER_MAX   = '1;

  logic w_act_prev;
  logic w_press_edge;
  logic w_rel_edge;

  state_t r_state;
  state_t w_state_next;
  logic [CNTW-1:0] r_timer;
  logic w_reload;
  logic w_short, w_double, w_long, w_repeat;
  logic r_evt_short, r_evt_double, r_evt_long, r_evt_repeat;

  btn_edge_detect #(
    .ACTIVE_LOW(ACTIVE_LOW)
  ) u_edge (
    .i_clk       (clk_100K),
    .i_rst_n     (rst_n),
    .i_btn       (btn_i),
    .o_act_prev  (w_act_prev),
    .o_press_edge(w_press_edge),
    .o_rel_edge  (w_rel_edge)
  );

  always_comb begin
    w_state_next = r_state;
    w_reload     = 1'b0;
    w_short      = 1'b0;
    w_double     = 1'b0;
    w_long       = 1'b0;
    w_repeat     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_press_edge) w_state_next = PRESS1;
      end
      PRESS1: begin
        if (w_rel_edge) begin
          w_state_next = WAIT2;
        end else if (r_timer == LONG_LAST) begin
          w_state_next = HELD;
          w_long       = 1'b1;
        end
      end
      WAIT2: begin
        if (w_press_edge) begin
          w_state_next = PRESS2;
        end else if (r_timer == DCLICK_LAST) begin
          w_state_next = IDLE;
          w_short      = 1'b1;
        end
      end
      PRESS2: begin
        if (w_rel_edge) begin
          w_state_next = IDLE;
          w_double     = 1'b1;
        end else if (r_timer == LONG_LAST) begin
          // A click followed by a long hold reports both gestures together.
          w_state_next = HELD;
          w_short      = 1'b1;
          w_long       = 1'b1;
        end
      end
      HELD: begin
        if (w_rel_edge) begin
          w_state_next = IDLE;
        end else if (r_timer == REPEAT_LAST) begin
          w_repeat = 1'b1;
          w_reload = 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_100K or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Saturating timer, restarted whenever the state changes or a repeat reloads it.
  always_ff @(posedge clk_100K or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (w_reload || (w_state_next != r_state)) begin
      r_timer <= '0;
    end else if (r_timer != TIMER_MAX) begin
      r_timer <= r_timer + CNTW'(1);
    end
  end

  always_ff @(posedge clk_100K or negedge rst_n) begin
    if (!rst_n) begin
      r_evt_short  <= 1'b0;
      r_evt_double <= 1'b0;
      r_evt_long   <= 1'b0;
      r_evt_repeat <= 1'b0;
    end else begin
      r_evt_short  <= w_short;
      r_evt_double <= w_double;
      r_evt_long   <= w_long;
      r_evt_repeat <= w_repeat;
    end
  end

  assign pressed    = w_act_prev;
  assign evt_short  = r_evt_short;
  assign evt_double = r_evt_double;
  assign evt_long   = r_evt_long;
  assign evt_repeat = r_evt_repeat;

endmodule

// File: tb/tb_button_event_decoder.sv
// Randomized and directed gesture stimulus for button_event_decoder, checked every cycle
// against an absolute-time gesture model, plus literal timing/count expectations per gesture.
module tb_button_event_decoder;

  localparam bit ACTIVE_LOW = 1'b1;
  localparam int L  = 100;
  localparam int DC = 30;
  localparam int R  = 20;

  logic clk_100K = 1'b0;
  logic rst_n    = 1'b1;
  logic btn_i    = 1'b1;
  logic pressed, evt_short, evt_double, evt_long, evt_repeat;

  button_event_decoder #(
    .ACTIVE_LOW (ACTIVE_LOW),
    .LONG_PRDS  (L),
    .DCLICK_PRDS(DC),
    .REPEAT_PRDS(R),
    .CNTW       (8)
  ) dut (
    .clk_100K  (clk_100K),
    .rst_n     (rst_n),
    .btn_i     (btn_i),
    .pressed   (pressed),
    .evt_short (evt_short),
    .evt_double(evt_double),
    .evt_long  (evt_long),
    .evt_repeat(evt_repeat)
  );

  always #5 clk_100K = ~clk_100K;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic chk_en = 1'b0;

  always @(posedge clk_100K) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Gesture model: phases with absolute entry times; a timeout is "elapsed == period".
  localparam int PH_IDLE = 0, PH_P1 = 1, PH_W2 = 2, PH_P2 = 3, PH_HELD = 4;
  int   m_phase = PH_IDLE, m_enter = 0, m_now = 0;
  logic m_prev = 1'b0, m_pressed = 1'b0;
  logic m_s = 1'b0, m_d = 1'b0, m_l = 1'b0, m_r = 1'b0;
  int   n_phase, n_enter, el;
  logic c_act, c_pe, c_re, n_s, n_d, n_l, n_r;

  always_comb begin
    c_act   = btn_i ^ ACTIVE_LOW;
    c_pe    = c_act & ~m_prev;
    c_re    = ~c_act & m_prev;
    el      = m_now - m_enter;
    n_phase = m_phase;
    n_enter = m_enter;
    n_s = 1'b0; n_d = 1'b0; n_l = 1'b0; n_r = 1'b0;
    case (m_phase)
      PH_IDLE: if (c_pe) begin n_phase = PH_P1; n_enter = m_now; end
      PH_P1: begin
        if (c_re) begin n_phase = PH_W2; n_enter = m_now; end
        else if (el == L) begin n_phase = PH_HELD; n_enter = m_now; n_l = 1'b1; end
      end
      PH_W2: begin
        if (c_pe) begin n_phase = PH_P2; n_enter = m_now; end
        else if (el == DC) begin n_phase = PH_IDLE; n_enter = m_now; n_s = 1'b1; end
      end
      PH_P2: begin
        if (c_re) begin n_phase = PH_IDLE; n_enter = m_now; n_d = 1'b1; end
        else if (el == L) begin
          n_phase = PH_HELD; n_enter = m_now; n_s = 1'b1; n_l = 1'b1;
        end
      end
      PH_HELD: begin
        if (c_re) begin n_phase = PH_IDLE; n_enter = m_now; end
        else if (el > 0 && (el % R) == 0) n_r = 1'b1;
      end
      default: n_phase = PH_IDLE;
    endcase
  end

  always @(posedge clk_100K or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= PH_IDLE; m_prev <= 1'b0; m_pressed <= 1'b0;
      m_s <= 1'b0; m_d <= 1'b0; m_l <= 1'b0; m_r <= 1'b0;
    end else begin
      m_now     <= m_now + 1;
      m_phase   <= n_phase;
      m_enter   <= n_enter;
      m_prev    <= c_act;
      m_pressed <= c_act;
      m_s <= n_s; m_d <= n_d; m_l <= n_l; m_r <= n_r;
    end
  end

  initial begin
    wait (chk_en);
    forever begin
      @(negedge clk_100K);
      chk("pressed", pressed, m_pressed);
      chk("evt_short", evt_short, m_s);
      chk("evt_double", evt_double, m_d);
      chk("evt_long", evt_long, m_l);
      chk("evt_repeat", evt_repeat, m_r);
    end
  end

  // Event counters and cycle stamps for the literal per-gesture expectations.
  int cnt_s, cnt_d, cnt_l, cnt_r, cnt_sl;
  int at_s, at_d, at_l, at_r1, at_r;

  task automatic clear_counts();
    cnt_s = 0; cnt_d = 0; cnt_l = 0; cnt_r = 0; cnt_sl = 0;
    at_s = -1000; at_d = -1000; at_l = -1000; at_r1 = -1000; at_r = -1000;
  endtask

  initial begin
    clear_counts();
    forever begin
      @(negedge clk_100K);
      if (evt_short)  begin cnt_s++; at_s = cyc; end
      if (evt_double) begin cnt_d++; at_d = cyc; end
      if (evt_long)   begin cnt_l++; at_l = cyc; end
      if (evt_short && evt_long) cnt_sl++;
      if (evt_repeat) begin
        if (cnt_r == 0) at_r1 = cyc;
        cnt_r++; at_r = cyc;
      end
    end
  end

  // Hold btn_i at b for n sampling edges; mark is the cycle stamp of the first sampling edge.
  task automatic drive(input logic b, input int n, output int mark);
    btn_i = b;
    mark  = cyc + 1;
    repeat (n) @(negedge clk_100K);
  endtask

  int mk, mk2, dummy;

  initial begin
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk_100K);
    chk("reset_outputs", {pressed, evt_short, evt_double, evt_long, evt_repeat}, 0);
    #2 rst_n = 1'b1;
    @(negedge clk_100K);
    drive(1'b1, 20, dummy);

    // Single click
    clear_counts();
    drive(1'b0, 10, dummy);
    drive(1'b1, 60, mk);
    chk("single_short_cnt", cnt_s, 1);
    chk("single_short_delay", at_s - mk, 30);
    chk("single_other_cnt", cnt_d + cnt_l + cnt_r, 0);

    // Double click
    clear_counts();
    drive(1'b0, 10, dummy);
    drive(1'b1, 10, dummy);
    drive(1'b0, 10, dummy);
    drive(1'b1, 60, mk);
    chk("double_cnt", cnt_d, 1);
    chk("double_delay", at_d - mk, 0);
    chk("double_no_short", cnt_s, 0);

    // Long press with repeats
    clear_counts();
    drive(1'b0, 145, mk);
    drive(1'b1, 60, dummy);
    chk("long_cnt", cnt_l, 1);
    chk("long_delay", at_l - mk, 100);
    chk("repeat_cnt", cnt_r, 2);
    chk("repeat1_delay", at_r1 - mk, 120);
    chk("repeat2_delay", at_r - mk, 140);
    chk("long_no_short", cnt_s + cnt_d, 0);

    // Click then hold; release collides with the first repeat timeout
    clear_counts();
    drive(1'b0, 10, dummy);
    drive(1'b1, 10, dummy);
    drive(1'b0, 120, mk);
    drive(1'b1, 60, dummy);
    chk("clickhold_short_long_same", cnt_sl, 1);
    chk("clickhold_long_delay", at_l - mk, 100);
    chk("clickhold_short_cnt", cnt_s, 1);
    chk("clickhold_no_repeat", cnt_r + cnt_d, 0);

    // Second press on the WAIT2 timeout edge
    clear_counts();
    drive(1'b0, 10, dummy);
    drive(1'b1, 30, dummy);
    drive(1'b0, 10, dummy);
    drive(1'b1, 60, dummy);
    chk("w2_boundary_double", cnt_d, 1);
    chk("w2_boundary_no_short", cnt_s, 0);

    // Release at PRESS1 cycle 99, and on the long-timeout edge itself
    for (int n = 99; n <= 101; n++) begin
      clear_counts();
      drive(1'b0, n, dummy);
      drive(1'b1, 60, dummy);
      chk($sformatf("p1_len%0d_long", n), cnt_l, (n == 101) ? 1 : 0);
      chk($sformatf("p1_len%0d_short", n), cnt_s, (n == 101) ? 0 : 1);
    end

    // Reset mid-gesture
    drive(1'b0, 50, dummy);
    chk("pre_reset_pressed", pressed, 1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", {pressed, evt_short, evt_double, evt_long, evt_repeat}, 0);
    btn_i = 1'b1;
    repeat (4) @(negedge clk_100K);
    #2 rst_n = 1'b1;
    @(negedge clk_100K);
    clear_counts();
    drive(1'b1, 200, dummy);
    chk("post_reset_quiet", cnt_s + cnt_d + cnt_l + cnt_r, 0);

    // Button held through reset release
    btn_i = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk_100K);
    #2 rst_n = 1'b1;
    @(negedge clk_100K);
    mk2 = cyc;
    clear_counts();
    chk("held_reset_pressed", pressed, 1);
    drive(1'b0, 104, dummy);
    drive(1'b1, 60, dummy);
    chk("held_reset_long", cnt_l, 1);
    chk("held_reset_long_delay", at_l - mk2, 100);

    // Randomized gestures around the interesting durations, with occasional resets
    for (int i = 0; i < 80; i++) begin
      int sel, len;
      sel = $urandom_range(0, 3);
      case (sel)
        0: len = $urandom_range(1, 12);
        1: len = $urandom_range(25, 35);
        2: len = $urandom_range(95, 105);
        default: len = $urandom_range(110, 160);
      endcase
      drive(i[0] ? 1'b1 : 1'b0, len, dummy);
      if ($urandom_range(0, 19) == 0) begin
        #3 rst_n = 1'b0;
        @(negedge clk_100K);
        #3 rst_n = 1'b1;
        @(negedge clk_100K);
      end
    end
    drive(1'b1, 60, dummy);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
